uart_cmd_decoder: RTL and testbench
===================================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the maximum decimal digits accepted by the load command.
REQ-002 The block SHALL have parameter VALUE_W, default 14, giving the width of load_value (holds 0..9999).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have port rx_data  in  8  received byte; valid only while rx_done=1.
REQ-007 The block SHALL have port rx_done  in  1  one-cycle strobe, one per received byte.
REQ-008 The block SHALL have port cmd_run  out  1  one-cycle pulse, run/stop toggle request.
REQ-009 The block SHALL have port cmd_clear  out  1  one-cycle pulse, counter clear request.
REQ-010 The block SHALL have port cmd_mode  out  1  one-cycle pulse, mode change request.
REQ-011 The block SHALL have port cmd_load  out  1  one-cycle pulse; load_value is valid in the same cycle.
REQ-012 The block SHALL have port load_value  out  VALUE_W  parsed decimal value; holds until the next load.
REQ-013 The block SHALL have port tx_data  out  8  response byte toward the TX FIFO.
REQ-014 The block SHALL have port tx_push  out  1  TX FIFO write enable.
REQ-015 The block SHALL have port tx_full  in  1  TX FIFO full; no push while high.
REQ-016 The block SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, DIGIT and RESP.
REQ-018 In IDLE, rx_done with 'R'/'r', 'C'/'c' or 'M'/'m' SHALL pulse cmd_run, cmd_clear or cmd_mode respectively in the next cycle, and SHALL enter RESP with response "OK\r\n".
REQ-019 In IDLE, rx_done with 'S'/'s' SHALL clear the accumulator and the digit count, then enter DIGIT.
REQ-020 In IDLE, CR (0x0D), LF (0x0A) and space (0x20) SHALL be ignored, with no response.
REQ-021 In IDLE, any other byte SHALL enter RESP with response "ER\r\n", with no command pulse.
REQ-022 In DIGIT, an ASCII '0'..'9' byte with count<DIGITS SHALL update the accumulator to acc*10+digit and increment count.
REQ-023 In DIGIT, a CR or LF byte with count>=1 SHALL, in the next cycle, pulse cmd_load, register load_value=acc, and enter RESP with response "OK".
REQ-024 In DIGIT, any of the following SHALL abandon the accumulator without changing load_value and enter RESP with response "ER": CR/LF with count=0, a digit with count=DIGITS, or any other byte.
REQ-025 In RESP, the block SHALL emit 4 bytes in order: 'O','K' or 'E','R', then 0x0D, 0x0A.
REQ-026 tx_push SHALL equal (state==RESP && !tx_full).
REQ-027 tx_data SHALL always show the current response byte.
REQ-028 The byte index SHALL advance only on a cycle where tx_push=1.
REQ-029 After the 4th push the FSM SHALL return to IDLE in the next cycle.
REQ-030 While tx_full=1 in RESP, the block SHALL hold the byte index and tx_data and SHALL NOT time out.
REQ-031 rx_done while in RESP SHALL be dropped: no parse, no pulse, no effect on the response.
REQ-032 Command pulse latency SHALL be exactly 1 cycle after rx_done.
REQ-033 The first tx_push SHALL occur no earlier than the same cycle as the command pulse.
REQ-034 At most one cmd_* output SHALL be high in any cycle.
REQ-035 The accumulator SHALL NOT wrap; with DIGITS=4 its maximum is 9999, which fits VALUE_W=14.

Reset
REQ-036 While rst=0, the block SHALL hold state=IDLE and set cmd_run, cmd_clear, cmd_mode, cmd_load, tx_push and busy to 0.
REQ-037 While rst=0, the block SHALL set load_value, the accumulator, the digit count and the byte index to 0, and tx_data to 0x00.
REQ-038 Reset asserted mid-response SHALL abort the response immediately; no partial bytes SHALL be pushed after rst rises.
REQ-039 The first rx_done SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-040 Package uart_cmd_pkg SHALL hold the state enum and the ASCII constants (R, C, M, S, CR, LF, SP, '0', '9').
REQ-041 Package uart_cmd_pkg SHALL hold the two 4-byte response tables.
REQ-042 Sub-module uart_resp_tx SHALL hold the RESP byte sequencer (start, ok/err select, tx_full stall, done); parsing stays in uart_cmd_decoder.

Verification
REQ-043 Bench: send 'r' -> cmd_run high exactly 1 cycle after rx_done; pushes 0x4F,0x4B,0x0D,0x0A; busy returns to 0.
REQ-044 Bench: send "S1234\r" -> cmd_load pulse with load_value=1234; response "OK\r\n".
REQ-045 Bench: send "S12345\r" -> no cmd_load and load_value unchanged; the response "ER\r\n" is produced when the 5th digit arrives, and the trailing CR is ignored in IDLE.
REQ-046 Bench: hold tx_full=1 for 10 cycles during RESP after 'C' -> no push during the stall; all 4 bytes are delivered in order once tx_full falls.
REQ-047 Bench: send 'M' then a second byte while busy -> second byte dropped; exactly one cmd_mode pulse and one response.
REQ-048 Bench: assert rst=0 after the 2nd response byte -> outputs 0 and state IDLE; a fresh 'R' yields a complete "OK\r\n".

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and response tables for the UART command decoder.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIGIT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  // Element 0 is sent first.
  localparam logic [3:0][7:0] RESP_OK = {ASCII_LF, ASCII_CR, 8'h4B, 8'h4F};
  localparam logic [3:0][7:0] RESP_ER = {ASCII_LF, ASCII_CR, 8'h52, 8'h45};

  // Fold lower-case letters onto upper case so commands are case-insensitive.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) ? (b - 8'h20) : b;
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of the decoder's RX input, command outputs and TX FIFO handshake.
interface uart_cmd_decoder_if #(
  parameter int VALUE_W = 14
);
  logic [7:0]         rx_data;
  logic               rx_done;
  logic               cmd_run;
  logic               cmd_clear;
  logic               cmd_mode;
  logic               cmd_load;
  logic [VALUE_W-1:0] load_value;
  logic [7:0]         tx_data;
  logic               tx_push;
  logic               tx_full;
  logic               busy;

  // Driver side (UART RX front end / TX FIFO / testbench).
  modport master (
    output rx_data, rx_done, tx_full,
    input  cmd_run, cmd_clear, cmd_mode, cmd_load, load_value, tx_data, tx_push, busy
  );

  // Decoder side.
  modport slave (
    input  rx_data, rx_done, tx_full,
    output cmd_run, cmd_clear, cmd_mode, cmd_load, load_value, tx_data, tx_push, busy
  );
endinterface

// File: rtl/uart_resp_tx.sv
// Response byte sequencer: walks a 4-byte OK/ER table into the TX FIFO,
// stalling while the FIFO is full and flagging the final push.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_ok,
  input  logic       i_active,
  input  logic       i_tx_full,
  output logic [7:0] o_tx_data,
  output logic       o_tx_push,
  output logic       o_done
);
  logic [1:0] r_idx;
  logic       r_ok;
  logic       w_push;

  assign w_push = i_active && !i_tx_full;

  // Latch the response kind on start; advance the byte index only on a push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx <= 2'd0;
      r_ok  <= 1'b0;
    end else if (i_start) begin
      r_idx <= 2'd0;
      r_ok  <= i_ok;
    end else if (w_push) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  assign o_tx_push = w_push;
  assign o_tx_data = !i_active ? 8'h00 : (r_ok ? RESP_OK[r_idx] : RESP_ER[r_idx]);
  assign o_done    = w_push && (r_idx == 2'd3);

endmodule

// File: rtl/uart_cmd_decoder.sv
// ASCII command parser: single-letter commands R/C/M and a decimal load
// command "S<digits><CR|LF>", each answered with "OK\r\n" or "ER\r\n".
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
) (
  input logic               clk,
  input logic               rst,
  uart_cmd_decoder_if.slave bus
);
  localparam int CNT_W = $clog2(DIGITS + 1);

  state_t             r_state;
  logic [VALUE_W-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cmd_run, r_cmd_clear, r_cmd_mode, r_cmd_load;
  logic [VALUE_W-1:0] r_load_value;

  state_t             w_next_state;
  logic [VALUE_W-1:0] w_acc_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_run_next, w_clear_next, w_mode_next, w_load_next;
  logic [VALUE_W-1:0] w_load_value_next;
  logic               w_start, w_ok, w_done;
  logic [7:0]         w_byte;
  logic [3:0]         w_digit_val;
  logic               w_is_digit, w_is_eol;
  logic [7:0]         w_tx_data;
  logic               w_tx_push;

  assign w_byte      = to_upper(bus.rx_data);
  assign w_digit_val = bus.rx_data[3:0];
  assign w_is_digit  = (bus.rx_data >= ASCII_0) && (bus.rx_data <= ASCII_9);
  assign w_is_eol    = (bus.rx_data == ASCII_CR) || (bus.rx_data == ASCII_LF);

  // State, accumulator and registered command pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_cmd_run    <= 1'b0;
      r_cmd_clear  <= 1'b0;
      r_cmd_mode   <= 1'b0;
      r_cmd_load   <= 1'b0;
      r_load_value <= '0;
    end else begin
      r_state      <= w_next_state;
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_cmd_run    <= w_run_next;
      r_cmd_clear  <= w_clear_next;
      r_cmd_mode   <= w_mode_next;
      r_cmd_load   <= w_load_next;
      r_load_value <= w_load_value_next;
    end
  end

  // Parse the incoming byte; bytes arriving while a response is out are dropped.
  always_comb begin
    w_next_state      = r_state;
    w_acc_next        = r_acc;
    w_cnt_next        = r_cnt;
    w_run_next        = 1'b0;
    w_clear_next      = 1'b0;
    w_mode_next       = 1'b0;
    w_load_next       = 1'b0;
    w_load_value_next = r_load_value;
    w_start           = 1'b0;
    w_ok              = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_done) begin
          if (w_byte == ASCII_R || w_byte == ASCII_C || w_byte == ASCII_M) begin
            w_run_next   = (w_byte == ASCII_R);
            w_clear_next = (w_byte == ASCII_C);
            w_mode_next  = (w_byte == ASCII_M);
            w_start      = 1'b1;
            w_ok         = 1'b1;
            w_next_state = ST_RESP;
          end else if (w_byte == ASCII_S) begin
            w_acc_next   = '0;
            w_cnt_next   = '0;
            w_next_state = ST_DIGIT;
          end else if (w_is_eol || bus.rx_data == ASCII_SP) begin
            w_next_state = ST_IDLE;
          end else begin
            w_start      = 1'b1;
            w_next_state = ST_RESP;
          end
        end
      end
      ST_DIGIT: begin
        if (bus.rx_done) begin
          if (w_is_digit && (r_cnt < CNT_W'(DIGITS))) begin
            w_acc_next = r_acc * VALUE_W'(10) + VALUE_W'(w_digit_val);
            w_cnt_next = r_cnt + CNT_W'(1);
          end else if (w_is_eol && (r_cnt != '0)) begin
            w_load_next       = 1'b1;
            w_load_value_next = r_acc;
            w_start           = 1'b1;
            w_ok              = 1'b1;
            w_next_state      = ST_RESP;
          end else begin
            w_start      = 1'b1;
            w_next_state = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (w_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  uart_resp_tx u_resp_tx (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_start),
    .i_ok      (w_ok),
    .i_active  (r_state == ST_RESP),
    .i_tx_full (bus.tx_full),
    .o_tx_data (w_tx_data),
    .o_tx_push (w_tx_push),
    .o_done    (w_done)
  );

  assign bus.cmd_run    = r_cmd_run;
  assign bus.cmd_clear  = r_cmd_clear;
  assign bus.cmd_mode   = r_cmd_mode;
  assign bus.cmd_load   = r_cmd_load;
  assign bus.load_value = r_load_value;
  assign bus.tx_data    = w_tx_data;
  assign bus.tx_push    = w_tx_push;
  assign bus.busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: directed scenarios followed by
// random byte streams, checked against a behavioural command model.
module tb_uart_cmd_decoder;
  localparam int DIGITS  = 4;
  localparam int VALUE_W = 14;

  localparam int K_RUN = 0, K_CLEAR = 1, K_MODE = 2, K_LOAD = 3;

  typedef struct {
    int kind;
    int value;
    int cyc;
  } cmd_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_decoder_if #(.VALUE_W(VALUE_W)) bus ();

  uart_cmd_decoder #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cmd_t       exp_cmd[$];
  logic [7:0] exp_tx[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Behavioural model state: bytes still owed, and an in-progress load command.
  int m_resp_left   = 0;
  bit m_collect     = 0;
  int m_acc         = 0;
  int m_cnt         = 0;
  int m_load_value  = 0;

  function automatic void start_resp(input bit ok);
    if (ok) begin exp_tx.push_back(8'h4F); exp_tx.push_back(8'h4B); end
    else    begin exp_tx.push_back(8'h45); exp_tx.push_back(8'h52); end
    exp_tx.push_back(8'h0D);
    exp_tx.push_back(8'h0A);
    m_resp_left = 4;
  endfunction

  function automatic void post_cmd(input int kind, input int value);
    cmd_t c;
    c.kind = kind; c.value = value; c.cyc = cyc;
    exp_cmd.push_back(c);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit is_dig;
    bit is_eol;
    is_dig = (b >= 8'd48) && (b <= 8'd57);
    is_eol = (b == 8'd13) || (b == 8'd10);
    if (m_collect) begin
      if (is_dig && m_cnt < DIGITS) begin
        m_acc = m_acc * 10 + (int'(b) - 48);
        m_cnt++;
      end else if (is_eol && m_cnt > 0) begin
        m_collect = 0;
        m_load_value = m_acc;
        post_cmd(K_LOAD, m_acc);
        start_resp(1);
      end else begin
        m_collect = 0;
        start_resp(0);
      end
    end else begin
      case (b)
        "R", "r": begin post_cmd(K_RUN, 0);   start_resp(1); end
        "C", "c": begin post_cmd(K_CLEAR, 0); start_resp(1); end
        "M", "m": begin post_cmd(K_MODE, 0);  start_resp(1); end
        "S", "s": begin m_collect = 1; m_acc = 0; m_cnt = 0; end
        8'd13, 8'd10, 8'd32: ;
        default: start_resp(0);
      endcase
    end
  endfunction

  // Model advances on every clock edge; reset wipes everything owed.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_resp_left = 0; m_collect = 0; m_acc = 0; m_cnt = 0; m_load_value = 0;
        exp_tx.delete();
        exp_cmd.delete();
      end else begin
        cyc++;
        if (m_resp_left > 0) begin
          if (!bus.tx_full) m_resp_left--;
        end else if (bus.rx_done) begin
          model_byte(bus.rx_data);
        end
      end
    end
  end

  // Monitor: compare DUT outputs against the scoreboard on the falling edge.
  initial begin
    cmd_t       c;
    logic [7:0] b;
    int         ak;
    bit         exp_busy;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if ({bus.cmd_run, bus.cmd_clear, bus.cmd_mode, bus.cmd_load, bus.tx_push, bus.busy} != 6'd0 ||
            bus.load_value != '0 || bus.tx_data != 8'h00) begin
          errors++;
          $display("FAIL reset_outputs: got cmds=%b push=%b busy=%b load_value=%0d tx_data=%h, required all zero",
                   {bus.cmd_run, bus.cmd_clear, bus.cmd_mode, bus.cmd_load}, bus.tx_push, bus.busy,
                   bus.load_value, bus.tx_data);
        end
      end else begin
        if (bus.cmd_run || bus.cmd_clear || bus.cmd_mode || bus.cmd_load) begin
          checks++;
          if ($countones({bus.cmd_run, bus.cmd_clear, bus.cmd_mode, bus.cmd_load}) > 1) begin
            errors++;
            $display("FAIL cmd_onehot: got %b, required at most one high",
                     {bus.cmd_run, bus.cmd_clear, bus.cmd_mode, bus.cmd_load});
          end
          ak = bus.cmd_run ? K_RUN : bus.cmd_clear ? K_CLEAR : bus.cmd_mode ? K_MODE : K_LOAD;
          checks++;
          if (exp_cmd.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got kind %0d at cycle %0d, required no command", ak, cyc);
          end else begin
            c = exp_cmd.pop_front();
            if (ak != c.kind || cyc != c.cyc || (ak == K_LOAD && int'(bus.load_value) != c.value)) begin
              errors++;
              $display("FAIL cmd_pulse: got kind %0d cycle %0d value %0d, required kind %0d cycle %0d value %0d",
                       ak, cyc, bus.load_value, c.kind, c.cyc, c.value);
            end else begin
              $display("cmd kind=%0d cycle=%0d load_value=%0d ok", ak, cyc, bus.load_value);
            end
          end
        end
        if (m_resp_left > 0 && exp_tx.size() > 0) begin
          checks++;
          if (bus.tx_data != exp_tx[0]) begin
            errors++;
            $display("FAIL tx_data: got %h, required %h (tx_full=%b)", bus.tx_data, exp_tx[0], bus.tx_full);
          end
        end
        if (bus.tx_push) begin
          checks++;
          if (bus.tx_full) begin
            errors++;
            $display("FAIL push_while_full: got tx_push=1 with tx_full=1, required 0");
          end
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL push_unexpected: got push of %h, required no push", bus.tx_data);
          end else begin
            b = exp_tx.pop_front();
            if (bus.tx_data != b) begin
              errors++;
              $display("FAIL push_byte: got %h, required %h", bus.tx_data, b);
            end else begin
              $display("push byte=%h ok", b);
            end
          end
        end
        exp_busy = m_collect || (m_resp_left > 0);
        checks++;
        if (bus.busy != exp_busy) begin
          errors++;
          $display("FAIL busy: got %b, required %b at cycle %0d", bus.busy, exp_busy, cyc);
        end
        checks++;
        if (int'(bus.load_value) != m_load_value) begin
          errors++;
          $display("FAIL load_value: got %0d, required %0d", bus.load_value, m_load_value);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
    bus.rx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_resp_left != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_resp_left != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: response still pending after %0d cycles, required completion", n);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      wait_idle();
      send(s[i]);
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [7:0] b;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_full = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 'r' accepted in the first cycle after reset release.
    send_str("r");
    send_str("S1234\r");
    send_str("S12345\r");

    // Stall the response after 'C' for 10 cycles.
    bus.tx_full = 1'b1;
    send("C");
    repeat (9) begin @(posedge clk); #1; end
    bus.tx_full = 1'b0;
    wait_idle();

    // Second byte while busy is dropped.
    send("M");
    send("R");
    wait_idle();

    // Reset after the second response byte, then a fresh 'R'.
    send("R");
    n = 0;
    while (m_resp_left != 2 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    send_str("R");

    // Random byte streams with random FIFO back-pressure.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin
          case ($urandom_range(0, 5))
            0: b = "R"; 1: b = "r"; 2: b = "C"; 3: b = "c"; 4: b = "M"; default: b = "m";
          endcase
        end
        2: b = ($urandom_range(0, 1) != 0) ? 8'h53 : 8'h73;
        3, 4, 5, 6: b = 8'(48 + $urandom_range(0, 9));
        7: b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        8: b = 8'h20;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bus.tx_full = ($urandom_range(0, 4) == 0);
      send(b);
      repeat ($urandom_range(0, 2)) begin
        bus.tx_full = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
      end
    end
    bus.tx_full = 1'b0;
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end

    checks++;
    if (exp_tx.size() != 0 || exp_cmd.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d bytes and %0d commands outstanding, required 0 and 0",
               exp_tx.size(), exp_cmd.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
